golden_nonce_collector: RTL and testbench
=========================================

// Module: golden_nonce_collector
// PURPOSE
//  Sits directly downstream of NUM_CORES mining cores in the multicore build. It captures each
//  core's golden-ticket strobe and its nonce, and arbitrates between cores round-robin. It then
//  queues each result, tagged with the core index, in a FIFO for the host comm/readout logic.
//  Nonces are passed through unmodified; nonce correction belongs to the core.
// PARAMETERS
//  NUM_CORES        4   number of mining cores feeding this block (1..16)
//  FIFO_DEPTH_LOG2  4   FIFO holds 2**FIFO_DEPTH_LOG2 entries
//  CORE_W           derived: max(1, clog2(NUM_CORES)), width of core index
// PORTS
//  hash_clk      in   1               single clock, all logic on posedge
//  reset         in   1               asynchronous, active-high reset
//  core_golden   in   NUM_CORES       per-core 1-cycle golden-ticket strobe
//  core_nonce    in   32*NUM_CORES    core i nonce at [32*i+31:32*i]; valid when strobe high
//  out_valid     out  1               FIFO head valid (FIFO not empty)
//  out_nonce     out  32              FIFO head nonce (show-ahead)
//  out_core      out  CORE_W          FIFO head core index
//  out_ready     in   1               consumer accepts head; pop when out_valid&&out_ready
//  fifo_count    out  FIFO_DEPTH_LOG2+1  current FIFO occupancy
//  drop_count    out  16              saturating count of lost tickets
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All pending flags are 0; FIFO empty; out_valid=0; fifo_count=0; drop_count=0.
//   - out_nonce=0 and out_core=0; RR pointer=NUM_CORES-1, so core 0 has first priority.
//  Capture stage, per core i:
//   - pending[i] is set and held_nonce[i]<=core_nonce[i] on an edge where core_golden[i]=1 and
//     (pending[i]=0 or core i is granted that same edge).
//   - If core_golden[i]=1 while pending[i]=1 and core i is not granted, the new ticket is
//     dropped: held nonce unchanged, drop_count+1, saturating at 16'hFFFF.
//   - Multiple cores dropping on one edge add the number dropped, still saturating.
//  Arbiter:
//   - Each edge, if FIFO not full and any pending bit is set, grant exactly one core.
//   - The grant goes to the first pending index after the RR pointer (wrapping mod NUM_CORES).
//   - The granted entry {i, held_nonce[i]} is written to the FIFO, pending[i] is cleared (unless
//     recaptured as above), and the RR pointer becomes i.
//   - FIFO full means no grant and no pointer change; pending entries wait. Full blocks the
//     write even if a pop occurs on the same edge.
//  FIFO:
//   - Synchronous, first-word fall-through. out_* reflect the head entry registered state.
//   - Push and pop on the same edge when not full: both happen, and fifo_count is unchanged.
//   - Pop when empty is ignored. Pointers wrap mod 2**FIFO_DEPTH_LOG2.
//   - out_nonce and out_core keep their last value when empty; do not rely on them.
//  Latency:
//   - Strobe at edge N is captured at N, written to the FIFO at N+1 if granted, and out_valid
//     is high after N+1 when the FIFO was empty.
//   - Worst case behind other pending cores: NUM_CORES edges to write.
//  Ordering: FIFO order = grant order; entries from the same core stay in strobe order.
//  Reset mid-operation: all pending, queued and counted tickets are discarded; no partial
//   entry appears after release.
// TESTING
//  1. Core 2 strobes nonce 32'hDEADBEEF once, out_ready=1 -> out_valid high for 1 cycle two
//     edges later with out_nonce=DEADBEEF, out_core=2; drop_count=0.
//  2. All 4 cores strobe together (nonces 0x10..0x13), out_ready=0 -> fifo_count reaches 4 after
//     4 edges; pops yield cores 0,1,2,3 in order.
//  3. Core 1 strobes on 2 consecutive edges while core 0 is also pending -> the second ticket is
//     dropped only if core 1 is not granted that edge; check drop_count=1 and held nonce = first.
//  4. out_ready=0 and 20 single tickets spaced apart (depth 16) -> fifo_count=16, 4 tickets stay
//     pending or are dropped per rules. Then out_ready=1 -> all stored entries drain in order,
//     and the pending ones follow.
//  5. FIFO holds 3 entries, a push and a pop on the same edge -> fifo_count stays 3 and the head
//     advances. drop_count forced to 0xFFFF saturates on another drop.
//  6. Assert reset with 5 entries queued and 2 pending -> out_valid=0, fifo_count=0,
//     drop_count=0 immediately (async). The first ticket after release reports core 0 priority.

Source files
------------

// File: rtl/golden_nonce_collector_if.sv
// Bundle between the mining cores, the golden-nonce collector and the host readout logic.
// Ticket strobes and nonces flow in; the queued {core, nonce} head flows out.
interface golden_nonce_collector_if #(
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned CORE_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
  logic [NUM_CORES-1:0]      core_golden;
  logic [32*NUM_CORES-1:0]   core_nonce;
  logic                      out_valid;
  logic [31:0]               out_nonce;
  logic [CORE_W-1:0]         out_core;
  logic                      out_ready;
  logic [FIFO_DEPTH_LOG2:0]  fifo_count;
  logic [15:0]               drop_count;

  // Cores plus consumer side: drives strobes and ready, observes the queue.
  modport master (
    output core_golden,
    output core_nonce,
    output out_ready,
    input  out_valid,
    input  out_nonce,
    input  out_core,
    input  fifo_count,
    input  drop_count
  );

  // The collector itself.
  modport slave (
    input  core_golden,
    input  core_nonce,
    input  out_ready,
    output out_valid,
    output out_nonce,
    output out_core,
    output fifo_count,
    output drop_count
  );
endinterface

// File: rtl/golden_nonce_collector.sv
// Captures golden-ticket strobes from NUM_CORES mining cores, arbitrates round-robin and queues
// {core index, nonce} in a first-word fall-through FIFO for the host readout logic.
module golden_nonce_collector #(
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  golden_nonce_collector_if.slave  bus
);

  localparam int unsigned CORE_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W   = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned ENTRY_W = CORE_W + 32;

  // Capture stage
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [31:0]          held_q [NUM_CORES];
  logic [31:0]          held_d [NUM_CORES];
  logic [15:0]          drop_q, drop_d;
  logic [4:0]           drop_num;
  logic [16:0]          drop_sum;

  // Arbiter
  logic [CORE_W-1:0]    rr_q, rr_d;
  logic                 grant_vld;
  logic [CORE_W-1:0]    grant_idx;
  logic [NUM_CORES-1:0] grant_oh;
  logic                 any_lo, any_hi;
  logic [CORE_W-1:0]    idx_lo, idx_hi;

  // FIFO
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [31:0]          wr_nonce;
  logic                 full, push, pop, head_vld;

  // Round-robin: lowest pending index above the pointer, else lowest pending overall.
  always_comb begin
    any_lo    = 1'b0;
    any_hi    = 1'b0;
    idx_lo    = '0;
    idx_hi    = '0;
    grant_oh  = '0;
    full      = (count_q == CNT_W'(DEPTH));
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        any_lo = 1'b1;
        idx_lo = CORE_W'(i);
      end
      if (pending_q[i] && (CORE_W'(i) > rr_q)) begin
        any_hi = 1'b1;
        idx_hi = CORE_W'(i);
      end
    end
    grant_vld = any_lo && !full;
    grant_idx = any_hi ? idx_hi : idx_lo;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      grant_oh[i] = grant_vld && (grant_idx == CORE_W'(i));
    end
    rr_d = grant_vld ? grant_idx : rr_q;
  end

  always_comb begin
    wr_nonce = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (grant_oh[i]) wr_nonce = held_q[i];
    end
    wr_entry = {grant_idx, wr_nonce};
  end

  // A core being granted this edge frees its slot, so a fresh strobe is recaptured, not dropped.
  always_comb begin
    pending_d = pending_q;
    held_d    = held_q;
    drop_num  = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (bus.core_golden[i] && (!pending_q[i] || grant_oh[i])) begin
        pending_d[i] = 1'b1;
        held_d[i]    = bus.core_nonce[32*i +: 32];
      end else if (grant_oh[i]) begin
        pending_d[i] = 1'b0;
      end else if (bus.core_golden[i]) begin
        drop_num = drop_num + 5'd1;
      end
    end
    drop_sum = {1'b0, drop_q} + {12'd0, drop_num};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Head register tracks the next entry so out_* come straight from flops.
  always_comb begin
    head_vld = (count_q != '0);
    push     = grant_vld;
    pop      = head_vld && bus.out_ready;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d   = head_q;
    if (count_d != '0) begin
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? wr_entry : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      drop_q    <= '0;
      rr_q      <= CORE_W'(NUM_CORES - 1);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
    end
  end

  // Storage without reset: only read behind a pending bit or the FIFO count.
  always_ff @(posedge hash_clk) begin
    held_q <= held_d;
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.out_valid  = head_vld;
  assign bus.out_nonce  = head_q[31:0];
  assign bus.out_core   = head_q[ENTRY_W-1:32];
  assign bus.fifo_count = count_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Directed bench for golden_nonce_collector: capture, round-robin order, drops, FIFO full,
// simultaneous push/pop, drop saturation and asynchronous reset.
module tb_golden_nonce_collector;

  logic hash_clk = 1'b0;
  logic reset    = 1'b1;
  int   passed   = 0;
  int   failed   = 0;
  int   total    = 0;

  always #5 hash_clk = ~hash_clk;

  golden_nonce_collector_if #(.NUM_CORES(4), .FIFO_DEPTH_LOG2(4)) bus ();

  golden_nonce_collector #(
    .NUM_CORES       (4),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .hash_clk (hash_clk),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.core_golden = '0;
    bus.out_ready   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_nonce(input int core, input logic [31:0] val);
    bus.core_nonce[32*core +: 32] = val;
  endtask

  initial begin
    bus.core_golden = '0;
    bus.core_nonce  = '0;
    bus.out_ready   = 1'b0;
    tick();

    // Reset state
    do_reset();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_drop", 32'(bus.drop_count), 32'd0);
    check("rst_nonce", bus.out_nonce, 32'd0);
    check("rst_core", 32'(bus.out_core), 32'd0);

    // Single ticket, two-edge latency, one-cycle valid
    bus.out_ready = 1'b1;
    bus.core_golden = 4'b0100;
    set_nonce(2, 32'hDEADBEEF);
    tick();
    bus.core_golden = '0;
    check("t1_valid_n", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_valid_n1", 32'(bus.out_valid), 32'd1);
    check("t1_nonce", bus.out_nonce, 32'hDEADBEEF);
    check("t1_core", 32'(bus.out_core), 32'd2);
    tick();
    check("t1_valid_n2", 32'(bus.out_valid), 32'd0);
    check("t1_drop", 32'(bus.drop_count), 32'd0);

    // All cores at once, round-robin from core 0
    do_reset();
    bus.core_golden = 4'b1111;
    for (int c = 0; c < 4; c++) set_nonce(c, 32'h10 + 32'(c));
    tick();
    bus.core_golden = '0;
    repeat (4) tick();
    check("t2_count", 32'(bus.fifo_count), 32'd4);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("t2_core", 32'(bus.out_core), 32'(c));
      check("t2_nonce", bus.out_nonce, 32'h10 + 32'(c));
      tick();
    end
    check("t2_empty", 32'(bus.out_valid), 32'd0);

    // Core 1 strobes twice while core 0 takes the grant: second ticket lost
    do_reset();
    bus.core_golden = 4'b0011;
    set_nonce(0, 32'hA0);
    set_nonce(1, 32'hB1);
    tick();
    bus.core_golden = 4'b0010;
    set_nonce(1, 32'hB2);
    tick();
    check("t3_drop", 32'(bus.drop_count), 32'd1);
    check("t3_head_core", 32'(bus.out_core), 32'd0);
    check("t3_head_nonce", bus.out_nonce, 32'hA0);
    // Strobe while granted: recaptured, no drop
    set_nonce(1, 32'hB3);
    tick();
    bus.core_golden = '0;
    check("t3_count2", 32'(bus.fifo_count), 32'd2);
    tick();
    check("t3_count3", 32'(bus.fifo_count), 32'd3);
    check("t3_drop_kept", 32'(bus.drop_count), 32'd1);

    // Three queued: push and pop on the same edge
    bus.core_golden = 4'b0100;
    set_nonce(2, 32'hC2);
    tick();
    bus.core_golden = '0;
    bus.out_ready = 1'b1;
    tick();
    check("t5_count", 32'(bus.fifo_count), 32'd3);
    check("t5_head_nonce", bus.out_nonce, 32'hB1);
    check("t5_head_core", 32'(bus.out_core), 32'd1);
    tick();
    check("t5_nonce2", bus.out_nonce, 32'hB3);
    check("t5_core2", 32'(bus.out_core), 32'd1);
    tick();
    check("t5_nonce3", bus.out_nonce, 32'hC2);
    check("t5_core3", 32'(bus.out_core), 32'd2);
    tick();
    check("t5_empty", 32'(bus.out_valid), 32'd0);

    // 20 spaced tickets into a 16-deep FIFO; last four wait pending
    do_reset();
    for (int k = 0; k < 20; k++) begin
      bus.core_golden = 4'(1 << (k % 4));
      set_nonce(k % 4, 32'h100 + 32'(k));
      tick();
      bus.core_golden = '0;
      tick();
    end
    check("t4_count", 32'(bus.fifo_count), 32'd16);
    check("t4_drop", 32'(bus.drop_count), 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("t4_valid", 32'(bus.out_valid), 32'd1);
      check("t4_nonce", bus.out_nonce, 32'h100 + 32'(k));
      check("t4_core", 32'(bus.out_core), 32'(k % 4));
      tick();
    end
    check("t4_empty", 32'(bus.out_valid), 32'd0);

    // Drop counter saturation with the FIFO full and every core pending
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus.core_golden = 4'(1 << (k % 4));
      tick();
    end
    bus.core_golden = '0;
    tick();
    check("sat_full", 32'(bus.fifo_count), 32'd16);
    bus.core_golden = 4'b1111;
    tick();
    check("sat_first", 32'(bus.drop_count), 32'd0);
    repeat (16383) tick();
    check("sat_fffc", 32'(bus.drop_count), 32'hFFFC);
    tick();
    check("sat_clip", 32'(bus.drop_count), 32'hFFFF);
    bus.core_golden = 4'b0001;
    tick();
    check("sat_hold", 32'(bus.drop_count), 32'hFFFF);
    bus.core_golden = '0;

    // Asynchronous reset with 5 queued, 2 pending and a drop recorded
    do_reset();
    bus.core_golden = 4'b1111;
    for (int c = 0; c < 4; c++) set_nonce(c, 32'hD0 + 32'(c));
    tick();
    bus.core_golden = '0;
    repeat (4) tick();
    bus.core_golden = 4'b0111;
    tick();
    bus.core_golden = 4'b0010;
    tick();
    bus.core_golden = '0;
    check("t6_pre_count", 32'(bus.fifo_count), 32'd5);
    check("t6_pre_drop", 32'(bus.drop_count), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check("t6_async_count", 32'(bus.fifo_count), 32'd0);
    check("t6_async_drop", 32'(bus.drop_count), 32'd0);
    check("t6_async_nonce", bus.out_nonce, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_no_stale", 32'(bus.out_valid), 32'd0);
    bus.core_golden = 4'b1001;
    set_nonce(0, 32'hE0);
    set_nonce(3, 32'hE3);
    tick();
    bus.core_golden = '0;
    tick();
    check("t6_first_core", 32'(bus.out_core), 32'd0);
    check("t6_first_nonce", bus.out_nonce, 32'hE0);
    check("t6_count1", 32'(bus.fifo_count), 32'd1);
    tick();
    check("t6_count2", 32'(bus.fifo_count), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
